operator_queue: RTL and testbench
=================================

// Module: operator_queue
// PURPOSE
//   Successor to the single operator latch. Samples the control unit's operator
//   bus (valid bit in the MSB, operator code below it) synchronously and queues
//   the codes in a DEPTH-entry FIFO, so the ALU sequencer can drain operators
//   at its own pace. Also holds the last captured operator, keeps an occupancy
//   count and raises a sticky overflow flag.
// PARAMETERS
//   OP_W       4   operator code width in bits
//   DEPTH      4   queue entries; power of 2, minimum 2
//   EDGE_MODE  1   1 = capture on rising edge of valid bit; 0 = capture every cycle valid is high
// PORTS
//   clk            in   1           system clock; all state updates on posedge
//   reset          in   1           synchronous, active-high
//   operatorPulse  in   OP_W+1      [OP_W] = valid/enable, [OP_W-1:0] = operator code
//   clear          in   1           synchronous flush of queue, storeOp and overflow
//   pop            in   1           consumer takes opOut this cycle (acted on only if opValid)
//   storeOp        out  OP_W        most recently captured operator code (held)
//   opOut          out  OP_W        operator at queue head; 0 when empty
//   opValid        out  1           queue non-empty
//   count          out  clog2(DEPTH)+1   current occupancy, 0..DEPTH
//   full           out  1           count == DEPTH
//   overflow       out  1           sticky: a capture was dropped while full
// BEHAVIOUR
//   Reset: storeOp=0, opOut=0, opValid=0, count=0, full=0, overflow=0, rd/wr ptrs=0.
//     Internal valid delay v_d resets to 1, so a valid bit held high across
//     reset release is NOT a capture in edge mode.
//   Capture event cap = EDGE_MODE ? (v & ~v_d) : v, with v = operatorPulse[OP_W]
//     and v_d = v registered every cycle (including during clear).
//   Push = cap & ~clear & (~full | pop_eff); pop_eff = pop & opValid & ~clear.
//   On cap (no clear): storeOp <= code at the next edge, even if the push is dropped.
//   Latency: capture at edge N -> storeOp, count and opValid update after edge N;
//     an entry pushed into an empty queue appears on opOut in the same cycle as opValid.
//   opOut is driven combinationally from mem[rd_ptr]; forced to 0 when empty.
//   Occupancy FSM (derived from count):
//     EMPTY -> PARTIAL on push; PARTIAL -> FULL on push reaching DEPTH;
//     FULL -> PARTIAL on pop; PARTIAL -> EMPTY on pop of the last entry;
//     push+pop in the same cycle leaves count unchanged.
//   Boundaries:
//     full & cap & ~pop -> capture dropped, overflow <= 1, queue unchanged, storeOp updated.
//     full & cap & pop  -> head leaves, new code enters; count stays DEPTH; no overflow.
//     empty & pop       -> ignored; count stays 0; opOut stays 0.
//     push into empty & pop in the same cycle -> the push happens; the pop is ignored
//       (nothing valid to pop).
//     Pointers wrap modulo DEPTH; the count arithmetic never wraps.
//     clear has priority over cap and pop: the queue empties, storeOp=0, overflow=0.
//     reset has priority over everything, including mid-sequence captures.
//     overflow is cleared only by reset or clear.
// TESTING
//   1 EDGE_MODE=1. Drive operatorPulse=5'b1_0011 for 3 cycles, then 0.
//     -> exactly one push; storeOp=3, opOut=3, count=1.
//   2 EDGE_MODE=0. Hold 5'b1_0101 for 3 cycles.
//     -> count=3; opOut=5; three pops drain the queue to count=0, opValid=0.
//   3 Push codes 1,2,3,4 (DEPTH=4), then push 9.
//     -> full=1, overflow=1, storeOp=9, opOut still 1; popping returns 1,2,3,4.
//   4 Queue full; assert a push of 7 together with pop.
//     -> the popped value is 1; count stays 4; overflow=0; the last pop returns 7.
//   5 Hold valid high through reset deassert (EDGE_MODE=1).
//     -> no capture; count=0 until valid falls and rises again.
//   6 Queue count=2, overflow=1; assert clear together with a capture of 6.
//     -> next cycle count=0, opValid=0, storeOp=0, overflow=0.

Source files
------------

// File: rtl/operator_queue.sv
// -----------------------------------------------------------------------------
// operator_queue
//   Samples the control unit's operator bus (valid bit in the MSB, operator code
//   below it) and queues captured codes in a DEPTH-entry FIFO. The ALU
//   sequencer drains the queue at its own pace. The block also holds the last
//   captured code, keeps an occupancy count and raises a sticky overflow flag.
//
// Parameters
//   OP_W       operator code width
//   DEPTH      queue entries (power of 2, >= 2)
//   EDGE_MODE  1: capture on rising edge of valid; 0: capture while valid high
//
// Ports
//   clk            system clock, all state changes on posedge
//   reset          synchronous, active-high
//   operatorPulse  [OP_W] valid, [OP_W-1:0] operator code
//   clear          synchronous flush of queue, storeOp and overflow
//   pop            consumer takes opOut this cycle (ignored when empty)
//   storeOp        most recently captured operator code
//   opOut          queue head, 0 when empty
//   opValid        queue non-empty
//   count          occupancy 0..DEPTH
//   full           count == DEPTH
//   overflow       sticky: a capture was dropped while full
// -----------------------------------------------------------------------------
module operator_queue #(
  parameter int OP_W      = 4,
  parameter int DEPTH     = 4,
  parameter int EDGE_MODE = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [OP_W:0]              operatorPulse,
  input  logic                       clear,
  input  logic                       pop,
  output logic [OP_W-1:0]            storeOp,
  output logic [OP_W-1:0]            opOut,
  output logic                       opValid,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_PARTIAL,
    ST_FULL
  } occ_state_t;

  occ_state_t         state_reg;
  logic [AW-1:0]      rd_ptr_reg;
  logic [AW-1:0]      wr_ptr_reg;
  logic [CW-1:0]      count_reg;
  logic [CW-1:0]      count_next;
  logic [OP_W-1:0]    store_reg;
  logic               overflow_reg;
  logic               v_d_reg;
  logic [OP_W-1:0]    mem [DEPTH];

  logic               v;
  logic [OP_W-1:0]    code;
  logic               cap;
  logic               not_empty;
  logic               is_full;
  logic               pop_eff;
  logic               push;

  assign v         = operatorPulse[OP_W];
  assign code      = operatorPulse[OP_W-1:0];
  assign cap       = (EDGE_MODE != 0) ? (v & ~v_d_reg) : v;
  assign not_empty = (state_reg != ST_EMPTY);
  assign is_full   = (state_reg == ST_FULL);

  // A pop frees the head slot in the same cycle, so a full queue still
  // accepts a capture when the consumer pops alongside it.
  assign pop_eff    = pop & not_empty & ~clear;
  assign push       = cap & ~clear & (~is_full | pop_eff);
  assign count_next = count_reg + CW'(push) - CW'(pop_eff);

  // Queue storage: one register per entry, written only on a push to its slot.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (push && (wr_ptr_reg == AW'(gi))) begin
          mem[gi] <= code;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_EMPTY;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      store_reg    <= '0;
      overflow_reg <= 1'b0;
      // Starting high means a valid bit held across reset release is not an edge.
      v_d_reg      <= 1'b1;
    end else begin
      v_d_reg <= v;
      if (clear) begin
        state_reg    <= ST_EMPTY;
        rd_ptr_reg   <= '0;
        wr_ptr_reg   <= '0;
        count_reg    <= '0;
        store_reg    <= '0;
        overflow_reg <= 1'b0;
      end else begin
        // storeOp follows every capture, even one dropped for lack of space.
        if (cap) begin
          store_reg <= code;
        end
        if (cap && is_full && !pop_eff) begin
          overflow_reg <= 1'b1;
        end
        if (push) begin
          wr_ptr_reg <= wr_ptr_reg + AW'(1);
        end
        if (pop_eff) begin
          rd_ptr_reg <= rd_ptr_reg + AW'(1);
        end
        count_reg <= count_next;
        if (count_next == '0) begin
          state_reg <= ST_EMPTY;
        end else if (count_next == DEPTH_C) begin
          state_reg <= ST_FULL;
        end else begin
          state_reg <= ST_PARTIAL;
        end
      end
    end
  end

  assign storeOp  = store_reg;
  assign opOut    = not_empty ? mem[rd_ptr_reg] : '0;
  assign opValid  = not_empty;
  assign count    = count_reg;
  assign full     = is_full;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_operator_queue.sv
// -----------------------------------------------------------------------------
// tb_operator_queue
//   Drives two instances (edge-capture and level-capture) from the same
//   inputs and compares every output against a queue-based reference model
//   after each clock edge. Directed scenarios come first, then random traffic.
// -----------------------------------------------------------------------------
module tb_operator_queue;

  localparam int OP_W  = 4;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [OP_W:0]   operatorPulse;
  logic            clear;
  logic            pop;

  logic [OP_W-1:0] store_w [2];
  logic [OP_W-1:0] out_w   [2];
  logic            valid_w [2];
  logic [2:0]      count_w [2];
  logic            full_w  [2];
  logic            ovf_w   [2];

  int errors = 0;
  int checks = 0;
  int step_no = 0;

  // Reference model state, index 1 = edge mode, 0 = level mode
  int mq [2][$];
  int mstore [2];
  bit movf [2];
  bit mvd [2];

  always #5 clk = ~clk;

  operator_queue #(.OP_W(OP_W), .DEPTH(DEPTH), .EDGE_MODE(1)) dut_edge (
    .clk(clk), .reset(reset), .operatorPulse(operatorPulse), .clear(clear), .pop(pop),
    .storeOp(store_w[1]), .opOut(out_w[1]), .opValid(valid_w[1]), .count(count_w[1]),
    .full(full_w[1]), .overflow(ovf_w[1])
  );

  operator_queue #(.OP_W(OP_W), .DEPTH(DEPTH), .EDGE_MODE(0)) dut_level (
    .clk(clk), .reset(reset), .operatorPulse(operatorPulse), .clear(clear), .pop(pop),
    .storeOp(store_w[0]), .opOut(out_w[0]), .opValid(valid_w[0]), .count(count_w[0]),
    .full(full_w[0]), .overflow(ovf_w[0])
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model(input int m, input logic rst, input logic [OP_W:0] pulse,
                       input logic clr, input logic pp);
    bit vb, cap, popok, canpush;
    if (rst) begin
      mq[m].delete();
      mstore[m] = 0;
      movf[m] = 0;
      mvd[m] = 1;
      return;
    end
    vb = pulse[OP_W];
    cap = (m == 1) ? (vb && !mvd[m]) : vb;
    mvd[m] = vb;
    if (clr) begin
      mq[m].delete();
      mstore[m] = 0;
      movf[m] = 0;
      return;
    end
    popok = pp && (mq[m].size() > 0);
    canpush = (mq[m].size() < DEPTH) || popok;
    if (cap) begin
      mstore[m] = int'(pulse[OP_W-1:0]);
      if (!canpush) movf[m] = 1;
    end
    if (popok) void'(mq[m].pop_front());
    if (cap && canpush) mq[m].push_back(int'(pulse[OP_W-1:0]));
  endtask

  task automatic compare_all();
    for (int m = 0; m < 2; m++) begin
      string p;
      int sz;
      p = (m == 1) ? "edge" : "level";
      sz = mq[m].size();
      chk({p, ".storeOp"}, 8'(store_w[m]), 8'(mstore[m]));
      chk({p, ".opOut"},   8'(out_w[m]),   (sz > 0) ? 8'(mq[m][0]) : 8'd0);
      chk({p, ".opValid"}, 8'(valid_w[m]), 8'(sz > 0));
      chk({p, ".count"},   8'(count_w[m]), 8'(sz));
      chk({p, ".full"},    8'(full_w[m]),  8'(sz == DEPTH));
      chk({p, ".overflow"},8'(ovf_w[m]),   8'(movf[m]));
    end
  endtask

  task automatic step(input logic rst, input logic [OP_W:0] pulse,
                      input logic clr, input logic pp);
    reset = rst;
    operatorPulse = pulse;
    clear = clr;
    pop = pp;
    @(posedge clk);
    model(1, rst, pulse, clr, pp);
    model(0, rst, pulse, clr, pp);
    #1;
    step_no++;
    $display("step %0d rst=%0b pulse=%b clr=%0b pop=%0b | edge cnt=%0d out=%0d | level cnt=%0d out=%0d",
             step_no, rst, pulse, clr, pp, count_w[1], out_w[1], count_w[0], out_w[0]);
    compare_all();
  endtask

  task automatic push_code(input int c);
    step(1'b0, {1'b1, 4'(c)}, 1'b0, 1'b0);
    step(1'b0, 5'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    operatorPulse = '0;
    clear = 1'b0;
    pop = 1'b0;

    // Reset state
    step(1'b1, 5'b0, 1'b0, 1'b0);
    step(1'b1, 5'b0, 1'b0, 1'b0);
    chk("reset.count", 8'(count_w[1]), 8'd0);
    chk("reset.opOut", 8'(out_w[1]), 8'd0);
    step(1'b0, 5'b0, 1'b0, 1'b0);

    // Edge mode: long valid gives one capture
    repeat (3) step(1'b0, 5'b1_0011, 1'b0, 1'b0);
    step(1'b0, 5'b0, 1'b0, 1'b0);
    chk("t1.storeOp", 8'(store_w[1]), 8'd3);
    chk("t1.opOut", 8'(out_w[1]), 8'd3);
    chk("t1.count", 8'(count_w[1]), 8'd1);
    step(1'b0, 5'b0, 1'b1, 1'b0);

    // Level mode: every valid cycle captures
    repeat (3) step(1'b0, 5'b1_0101, 1'b0, 1'b0);
    chk("t2.count", 8'(count_w[0]), 8'd3);
    chk("t2.opOut", 8'(out_w[0]), 8'd5);
    repeat (3) step(1'b0, 5'b0, 1'b0, 1'b1);
    chk("t2.drain_count", 8'(count_w[0]), 8'd0);
    chk("t2.drain_valid", 8'(valid_w[0]), 8'd0);

    // Fill then overflow
    step(1'b0, 5'b0, 1'b1, 1'b0);
    for (int c = 1; c <= 4; c++) push_code(c);
    step(1'b0, 5'b1_1001, 1'b0, 1'b0);
    chk("t3.full", 8'(full_w[1]), 8'd1);
    chk("t3.overflow", 8'(ovf_w[1]), 8'd1);
    chk("t3.storeOp", 8'(store_w[1]), 8'd9);
    chk("t3.opOut", 8'(out_w[1]), 8'd1);
    step(1'b0, 5'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      chk("t3.pop_order", 8'(out_w[1]), 8'(i));
      step(1'b0, 5'b0, 1'b0, 1'b1);
    end
    chk("t3.pop_empty_out", 8'(out_w[1]), 8'd0);
    step(1'b0, 5'b0, 1'b0, 1'b1);
    chk("t3.pop_empty_count", 8'(count_w[1]), 8'd0);

    // Push and pop together on a full queue
    step(1'b0, 5'b0, 1'b1, 1'b0);
    for (int c = 1; c <= 4; c++) push_code(c);
    step(1'b0, 5'b1_0111, 1'b0, 1'b1);
    chk("t4.count", 8'(count_w[1]), 8'd4);
    chk("t4.overflow", 8'(ovf_w[1]), 8'd0);
    chk("t4.head", 8'(out_w[1]), 8'd2);
    step(1'b0, 5'b0, 1'b0, 1'b0);
    repeat (3) step(1'b0, 5'b0, 1'b0, 1'b1);
    chk("t4.last", 8'(out_w[1]), 8'd7);
    step(1'b0, 5'b0, 1'b0, 1'b1);

    // Valid held through reset release
    step(1'b1, 5'b1_0010, 1'b0, 1'b0);
    step(1'b1, 5'b1_0010, 1'b0, 1'b0);
    step(1'b0, 5'b1_0010, 1'b0, 1'b0);
    step(1'b0, 5'b1_0010, 1'b0, 1'b0);
    chk("t5.no_capture", 8'(count_w[1]), 8'd0);
    step(1'b0, 5'b0, 1'b0, 1'b0);
    step(1'b0, 5'b1_0010, 1'b0, 1'b0);
    chk("t5.recapture", 8'(count_w[1]), 8'd1);

    // Clear wins over a simultaneous capture
    step(1'b0, 5'b0, 1'b1, 1'b0);
    for (int c = 1; c <= 4; c++) push_code(c);
    step(1'b0, 5'b1_1001, 1'b0, 1'b0);
    step(1'b0, 5'b0, 1'b0, 1'b1);
    step(1'b0, 5'b0, 1'b0, 1'b1);
    chk("t6.pre_count", 8'(count_w[1]), 8'd2);
    chk("t6.pre_ovf", 8'(ovf_w[1]), 8'd1);
    step(1'b0, 5'b1_0110, 1'b1, 1'b0);
    chk("t6.count", 8'(count_w[1]), 8'd0);
    chk("t6.opValid", 8'(valid_w[1]), 8'd0);
    chk("t6.storeOp", 8'(store_w[1]), 8'd0);
    chk("t6.overflow", 8'(ovf_w[1]), 8'd0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic r, cl, pp;
      logic [OP_W:0] pu;
      r  = ($urandom_range(63) == 0);
      cl = ($urandom_range(15) == 0);
      pp = $urandom_range(1);
      pu = {1'($urandom_range(1)), 4'($urandom_range(15))};
      step(r, pu, cl, pp);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
